// File: rtl/rr_arb4_16_pkg.sv
// Shared types, requester indices and the rotating-priority pick for rr_arb4_16.
package rr_arb4_16_pkg;

  typedef enum logic {
    ArbIdle = 1'b0,
    ArbXfer = 1'b1
  } arb_state_e;

  localparam logic [1:0] ReqFetch = 2'd0;
  localparam logic [1:0] ReqLdst  = 2'd1;
  localparam logic [1:0] ReqDma   = 2'd2;
  localparam logic [1:0] ReqDbg   = 2'd3;

  // First set bit of elig scanning last+1, last+2, last+3, last (mod 4).
  function automatic logic [1:0] rr_pick(input logic [3:0] elig, input logic [1:0] last);
    logic [1:0] idx;
    logic       found;
    rr_pick = last;
    found   = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && elig[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/rr_arb4_16_mux.sv
// Fixed 4-to-1 16-bit word select, steered by the arbiter's combinational winner.
module rr_arb4_16_mux
  import rr_arb4_16_pkg::*;
(
  input  logic [1:0]  sel_i,
  input  logic [15:0] d0_i,
  input  logic [15:0] d1_i,
  input  logic [15:0] d2_i,
  input  logic [15:0] d3_i,
  output logic [15:0] y_o
);

  always_comb begin
    y_o = d0_i;
    unique case (sel_i)
      ReqFetch: y_o = d0_i;
      ReqLdst:  y_o = d1_i;
      ReqDma:   y_o = d2_i;
      ReqDbg:   y_o = d3_i;
      default:  y_o = d0_i;
    endcase
  end

endmodule

// File: rtl/rr_arb4_16.sv
// Four-way round-robin arbiter onto one 16-bit valid/ready port.
// Optional ARB_LOCK_EN adds lock[3:0] for locked bursts by the current owner.
module rr_arb4_16
  import rr_arb4_16_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter logic [1:0]  RST_LAST = 2'd3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        req,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  input  logic [DATA_W-1:0] data3,
  input  logic              bus_ready,
`ifdef ARB_LOCK_EN
  input  logic [3:0]        lock,
`endif
  output logic              bus_valid,
  output logic [DATA_W-1:0] bus_data,
  output logic [1:0]        bus_id,
  output logic [3:0]        ack
);

  arb_state_e        state_q, state_d;
  logic [1:0]        last_q, last_d;
  logic [1:0]        id_q, id_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] mux_y;
  logic [1:0]        winner;
  logic [3:0]        elig;
  logic              complete, hold_lock, grant;

  rr_arb4_16_mux u_mux_4by16 (
    .sel_i (winner),
    .d0_i  (data0),
    .d1_i  (data1),
    .d2_i  (data2),
    .d3_i  (data3),
    .y_o   (mux_y)
  );

  always_comb begin
    complete = (state_q == ArbXfer) && bus_ready;
`ifdef ARB_LOCK_EN
    hold_lock = complete && lock[id_q] && req[id_q];
`else
    hold_lock = 1'b0;
`endif
    // The acked requester still has req high this cycle; exclude it unless locked.
    elig = req;
    if (complete && !hold_lock) elig[id_q] = 1'b0;
    winner = hold_lock ? id_q : rr_pick(elig, last_q);
    grant  = ((state_q == ArbIdle) || complete) && (|elig);

    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    data_d  = data_q;
    if (grant) begin
      state_d = ArbXfer;
      id_d    = winner;
      data_d  = mux_y;
      if (!hold_lock) last_d = winner;
    end else if (complete) begin
      state_d = ArbIdle;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ArbIdle;
      last_q  <= RST_LAST;
      id_q    <= 2'b00;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    bus_valid = (state_q == ArbXfer);
    bus_data  = data_q;
    bus_id    = id_q;
    ack       = 4'b0000;
    if (bus_valid && bus_ready) ack[id_q] = 1'b1;
  end

endmodule

// File: tb/tb_rr_arb4_16.sv
// Scoreboard bench for rr_arb4_16: expected {id, word} pushed at stimulus, popped on handshake.
module tb_rr_arb4_16;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] data0, data1, data2, data3;
  logic        bus_ready;
  logic        bus_valid;
  logic [15:0] bus_data;
  logic [1:0]  bus_id;
  logic [3:0]  ack;
`ifdef ARB_LOCK_EN
  logic [3:0]  lock;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [17:0] sb[$];
  logic [17:0] exp_v;

  always #5 clk = ~clk;

  rr_arb4_16 dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .data0     (data0),
    .data1     (data1),
    .data2     (data2),
    .data3     (data3),
    .bus_ready (bus_ready),
`ifdef ARB_LOCK_EN
    .lock      (lock),
`endif
    .bus_valid (bus_valid),
    .bus_data  (bus_data),
    .bus_id    (bus_id),
    .ack       (ack)
  );

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    req = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({bus_valid, bus_data, bus_id, ack} !== 23'd0) begin
      n_err++;
      $display("FAIL reset_state: got v=%b d=%h id=%0d ack=%b, want all zero",
               bus_valid, bus_data, bus_id, ack);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    @(negedge clk);
    req = 4'b0001; data0 = 16'hA5A5; bus_ready = 1'b1;
    sb.push_back({2'd0, 16'hA5A5});
    @(negedge clk);
    n_cmp++;
    if (bus_valid !== 1'b1) begin
      n_err++; $display("FAIL single_latency: bus_valid=%b want 1", bus_valid);
    end
    exp_v = sb.pop_front();
    n_cmp++;
    if ({bus_id, bus_data} !== exp_v) begin
      n_err++; $display("FAIL single_word: got id=%0d d=%h want id=%0d d=%h",
                        bus_id, bus_data, exp_v[17:16], exp_v[15:0]);
    end
    n_cmp++;
    if (ack !== 4'b0001) begin
      n_err++; $display("FAIL single_ack: got %b want 0001", ack);
    end
    req = 4'b0000;
    @(negedge clk);
    n_cmp++;
    if (bus_valid !== 1'b0) begin
      n_err++; $display("FAIL single_idle: bus_valid=%b want 0", bus_valid);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    req = 4'b1111; bus_ready = 1'b1;
    data0 = 16'h1000; data1 = 16'h1001; data2 = 16'h1002; data3 = 16'h1003;
    for (int i = 0; i < 5; i++) sb.push_back({2'(i % 4), 16'h1000 + 16'(i % 4)});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        n_cmp++; n_err++; $display("FAIL rr_queue: scoreboard empty at transfer %0d", i);
      end else begin
        exp_v = sb.pop_front();
        n_cmp++;
        if (bus_valid !== 1'b1 || {bus_id, bus_data} !== exp_v) begin
          n_err++; $display("FAIL rr_grant%0d: got v=%b id=%0d d=%h want v=1 id=%0d d=%h",
                            i, bus_valid, bus_id, bus_data, exp_v[17:16], exp_v[15:0]);
        end
        n_cmp++;
        if (ack !== (4'b0001 << exp_v[17:16])) begin
          n_err++; $display("FAIL rr_ack%0d: got %b want id %0d", i, ack, exp_v[17:16]);
        end
      end
      if (i == 4) req = 4'b0000;
    end
    @(negedge clk);
    n_cmp++;
    if (bus_valid !== 1'b0) begin
      n_err++; $display("FAIL rr_idle: bus_valid=%b want 0", bus_valid);
    end
  endtask

  task automatic test_stall();
    @(negedge clk);
    req = 4'b0100; data2 = 16'h1234; bus_ready = 1'b0;
    sb.push_back({2'd2, 16'h1234});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus_valid !== 1'b1 || {bus_id, bus_data} !== sb[0] || ack !== 4'b0000) begin
        n_err++; $display("FAIL stall_hold%0d: got v=%b id=%0d d=%h ack=%b want v=1 id=2 d=1234 ack=0000",
                          i, bus_valid, bus_id, bus_data, ack);
      end
      if (i == 2) data2 = 16'hFFFF;
    end
    bus_ready = 1'b1;
    #1;
    exp_v = sb.pop_front();
    n_cmp++;
    if (ack !== 4'b0100 || {bus_id, bus_data} !== exp_v) begin
      n_err++; $display("FAIL stall_done: got ack=%b id=%0d d=%h want ack=0100 id=2 d=1234",
                        ack, bus_id, bus_data);
    end
    req = 4'b0000;
    @(negedge clk);
    n_cmp++;
    if (bus_valid !== 1'b0) begin
      n_err++; $display("FAIL stall_idle: bus_valid=%b want 0", bus_valid);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    req = 4'b0010; data1 = 16'hBEEF; bus_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus_valid !== 1'b1 || bus_id !== 2'd1 || bus_data !== 16'hBEEF) begin
      n_err++; $display("FAIL arst_pre: got v=%b id=%0d d=%h want v=1 id=1 d=beef",
                        bus_valid, bus_id, bus_data);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus_valid, bus_data, bus_id, ack} !== 23'd0) begin
      n_err++; $display("FAIL arst_clear: got v=%b d=%h id=%0d ack=%b want all zero",
                        bus_valid, bus_data, bus_id, ack);
    end
    @(negedge clk);
    rst = 1'b0; bus_ready = 1'b1; data1 = 16'hCAFE;
    sb.push_back({2'd1, 16'hCAFE});
    @(negedge clk);
    exp_v = sb.pop_front();
    n_cmp++;
    if (bus_valid !== 1'b1 || {bus_id, bus_data} !== exp_v || ack !== 4'b0010) begin
      n_err++; $display("FAIL arst_regrant: got v=%b id=%0d d=%h ack=%b want v=1 id=1 d=cafe ack=0010",
                        bus_valid, bus_id, bus_data, ack);
    end
    req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_wrap();
    @(negedge clk);
    req = 4'b1000; data0 = 16'h0A0A; data3 = 16'h3333; bus_ready = 1'b1;
    sb.push_back({2'd3, 16'h3333});
    sb.push_back({2'd0, 16'h0A0A});
    sb.push_back({2'd3, 16'h3333});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        n_cmp++; n_err++; $display("FAIL wrap_queue: scoreboard empty at transfer %0d", i);
      end else begin
        exp_v = sb.pop_front();
        n_cmp++;
        if (bus_valid !== 1'b1 || {bus_id, bus_data} !== exp_v ||
            ack !== (4'b0001 << exp_v[17:16])) begin
          n_err++; $display("FAIL wrap_grant%0d: got v=%b id=%0d d=%h ack=%b want id=%0d d=%h",
                            i, bus_valid, bus_id, bus_data, ack, exp_v[17:16], exp_v[15:0]);
        end
      end
      if (i == 0) req = 4'b1001;
      else if (i == 1) req = 4'b1000;
      else req = 4'b0000;
    end
    @(negedge clk);
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock();
    apply_reset();
    lock = 4'b0010; req = 4'b0011; bus_ready = 1'b1;
    data0 = 16'h0100; data1 = 16'h0111;
    sb.push_back({2'd0, 16'h0100});
    for (int i = 0; i < 3; i++) sb.push_back({2'd1, 16'h0111});
    sb.push_back({2'd0, 16'h0100});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        n_cmp++; n_err++; $display("FAIL lock_queue: scoreboard empty at transfer %0d", i);
      end else begin
        exp_v = sb.pop_front();
        n_cmp++;
        if (bus_valid !== 1'b1 || {bus_id, bus_data} !== exp_v) begin
          n_err++; $display("FAIL lock_grant%0d: got v=%b id=%0d d=%h want id=%0d d=%h",
                            i, bus_valid, bus_id, bus_data, exp_v[17:16], exp_v[15:0]);
        end
      end
      if (i == 3) lock = 4'b0000;
      if (i == 4) req = 4'b0000;
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    rst = 1'b1; req = 4'b0000; bus_ready = 1'b0;
    data0 = '0; data1 = '0; data2 = '0; data3 = '0;
`ifdef ARB_LOCK_EN
    lock = 4'b0000;
`endif
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_async_reset();
    test_wrap();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++; $display("FAIL sb_drain: %0d expected transfers never seen, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
